// File: rtl/gfx_fb_pkg.sv
// Shared definitions for the double-buffered frame store: the swap FSM
// state encoding and the default number of visible pixels per frame.
package gfx_fb_pkg;

  // Default visible pixel count for a 240x160 frame.
  localparam int PIX_COUNT_DEFAULT = 240 * 160;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    SWAP = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_port_mux.sv
// Steers the graphics-side write request to the back buffer (~front_sel)
// and the VGA-side read request to the front buffer (front_sel). A buffer
// is never driven by both sides at once. Fields not in use drive zero.
module fb_port_mux #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 15
) (
  input  logic              front_sel,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_color,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] buf0_address,
  output logic [DATA_W-1:0] buf0_din,
  output logic              buf0_we,
  output logic              buf0_ce,
  output logic [ADDR_W-1:0] buf1_address,
  output logic [DATA_W-1:0] buf1_din,
  output logic              buf1_we,
  output logic              buf1_ce
);

  // Route the writer to the back buffer and the reader to the front buffer.
  always_comb begin
    buf0_address = '0;
    buf0_din     = '0;
    buf0_we      = 1'b0;
    buf0_ce      = 1'b0;
    buf1_address = '0;
    buf1_din     = '0;
    buf1_we      = 1'b0;
    buf1_ce      = 1'b0;
    if (front_sel) begin
      // buf1 displayed, buf0 being drawn
      if (wr_req) begin
        buf0_address = wr_addr;
        buf0_din     = wr_color;
        buf0_we      = 1'b1;
        buf0_ce      = 1'b1;
      end
      if (rd_req) begin
        buf1_address = rd_addr;
        buf1_ce      = 1'b1;
      end
    end else begin
      // buf0 displayed, buf1 being drawn
      if (wr_req) begin
        buf1_address = wr_addr;
        buf1_din     = wr_color;
        buf1_we      = 1'b1;
        buf1_ce      = 1'b1;
      end
      if (rd_req) begin
        buf0_address = rd_addr;
        buf0_ce      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_swap_arbiter.sv
// Double-buffer frame arbiter: the graphics side draws into the back
// buffer while the VGA side scans the front buffer; buffers swap only at
// a VGA frame boundary after the graphics side has finished a frame.
// Optional build macro FRAME_STATS_EN compiles in the repeat_count
// counter (frames re-shown because no new frame was ready); without it
// repeat_count is tied to zero.
module frame_swap_arbiter
  import gfx_fb_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 15,
  parameter int PIX_COUNT = PIX_COUNT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_color,
  output logic              wr_ready,
  input  logic              wr_frame_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_color,
  output logic              rd_valid,
  input  logic              rd_frame_done,
  output logic              toggle,
  output logic              front_sel,
  output logic [ADDR_W-1:0] buf0_address,
  output logic [DATA_W-1:0] buf0_din,
  output logic              buf0_we,
  output logic              buf0_ce,
  input  logic [DATA_W-1:0] buf0_dout,
  output logic [ADDR_W-1:0] buf1_address,
  output logic [DATA_W-1:0] buf1_din,
  output logic              buf1_we,
  output logic              buf1_ce,
  input  logic [DATA_W-1:0] buf1_dout,
  output logic [15:0]       repeat_count
);

  fb_state_e state_q, state_d;
  logic      front_sel_q, front_sel_d;
  logic      rd_valid_q, rd_valid_d;
  logic      rd_sel_q, rd_sel_d;
  logic      rd_oob_q, rd_oob_d;
  logic      wr_in_range, rd_in_range;
  logic      wr_req, rd_req;

  assign wr_in_range = (32'(wr_addr) < PIX_COUNT);
  assign rd_in_range = (32'(rd_addr) < PIX_COUNT);

  // Writes are only accepted while filling; reset blocks any write in its
  // own cycle even if the FSM register still shows FILL.
  assign wr_ready  = (state_q == FILL) && !reset;
  assign wr_req    = wr_en && wr_ready && wr_in_range;
  // Out-of-range reads never touch the RAM; they return zero instead.
  assign rd_req    = rd_en && rd_in_range;
  assign toggle    = (state_q == SWAP);
  assign front_sel = front_sel_q;

  // Next-state logic for the fill / hold / swap sequence.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    case (state_q)
      FILL: begin
        if (wr_frame_done && rd_frame_done) begin
          state_d = SWAP;
        end else if (wr_frame_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rd_frame_done) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d     = FILL;
        front_sel_d = ~front_sel_q;
      end
      default: state_d = FILL;
    endcase
  end

  // FSM and front-buffer index registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      front_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
    end
  end

  // Read qualifier plus the buffer index and range flag that go with the
  // RAM's one-cycle read latency. The select is captured from the front
  // index at request time, so a read issued during SWAP uses the old front.
  always_comb begin
    rd_valid_d = rd_en;
    rd_sel_d   = front_sel_q;
    rd_oob_d   = !rd_in_range;
  end

  // Read pipeline registers; only the valid bit needs a reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
    rd_sel_q <= rd_sel_d;
    rd_oob_q <= rd_oob_d;
  end

  // Return data: zero when not valid or when the address was out of range.
  always_comb begin
    rd_color = '0;
    if (rd_valid_q && !rd_oob_q) begin
      rd_color = rd_sel_q ? buf1_dout : buf0_dout;
    end
  end

  assign rd_valid = rd_valid_q;

`ifdef FRAME_STATS_EN
  logic [15:0] repeat_count_q, repeat_count_d;

  // Count VGA frame ends that found no finished back frame; saturating.
  always_comb begin
    repeat_count_d = repeat_count_q;
    if ((state_q == FILL) && rd_frame_done && !wr_frame_done &&
        (repeat_count_q != 16'hFFFF)) begin
      repeat_count_d = repeat_count_q + 16'd1;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      repeat_count_q <= 16'd0;
    end else begin
      repeat_count_q <= repeat_count_d;
    end
  end

  assign repeat_count = repeat_count_q;
`else
  assign repeat_count = 16'd0;
`endif

  fb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .front_sel    (front_sel_q),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_color     (wr_color),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .buf0_address (buf0_address),
    .buf0_din     (buf0_din),
    .buf0_we      (buf0_we),
    .buf0_ce      (buf0_ce),
    .buf1_address (buf1_address),
    .buf1_din     (buf1_din),
    .buf1_we      (buf1_we),
    .buf1_ce      (buf1_ce)
  );

endmodule

// File: tb/tb_frame_swap_arbiter.sv
// Directed bench for frame_swap_arbiter with two small 1-cycle-latency
// RAM models on the buffer ports (indexed by the low 8 address bits).
module tb_frame_swap_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_color = '0;
  logic              wr_ready;
  logic              wr_frame_done = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_color;
  logic              rd_valid;
  logic              rd_frame_done = 1'b0;
  logic              toggle;
  logic              front_sel;
  logic [ADDR_W-1:0] buf0_address, buf1_address;
  logic [DATA_W-1:0] buf0_din, buf1_din;
  logic              buf0_we, buf0_ce, buf1_we, buf1_ce;
  logic [DATA_W-1:0] buf0_dout = '0;
  logic [DATA_W-1:0] buf1_dout = '0;
  logic [15:0]       repeat_count;

  logic [DATA_W-1:0] mem0 [0:255] = '{0: 15'h7fff, 5: 15'h0abc, default: 15'h0};
  logic [DATA_W-1:0] mem1 [0:255] = '{default: 15'h0};

  int n_checks = 0;
  int n_fail   = 0;

  frame_swap_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PIX_COUNT (38400)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_color      (wr_color),
    .wr_ready      (wr_ready),
    .wr_frame_done (wr_frame_done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_color      (rd_color),
    .rd_valid      (rd_valid),
    .rd_frame_done (rd_frame_done),
    .toggle        (toggle),
    .front_sel     (front_sel),
    .buf0_address  (buf0_address),
    .buf0_din      (buf0_din),
    .buf0_we       (buf0_we),
    .buf0_ce       (buf0_ce),
    .buf0_dout     (buf0_dout),
    .buf1_address  (buf1_address),
    .buf1_din      (buf1_din),
    .buf1_we       (buf1_we),
    .buf1_ce       (buf1_ce),
    .buf1_dout     (buf1_dout),
    .repeat_count  (repeat_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (buf0_ce) begin
      if (buf0_we) mem0[buf0_address[7:0]] <= buf0_din;
      buf0_dout <= mem0[buf0_address[7:0]];
    end
    if (buf1_ce) begin
      if (buf1_we) mem1[buf1_address[7:0]] <= buf1_din;
      buf1_dout <= mem1[buf1_address[7:0]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL reset_toggle: got %b want 0", toggle); end
    n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL reset_front_sel: got %b want 0", front_sel); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_color !== 15'h0) begin n_fail++; $display("FAIL reset_rd_color: got %h want 0", rd_color); end
    n_checks++; if (repeat_count !== 16'h0) begin n_fail++; $display("FAIL reset_repeat_count: got %0d want 0", repeat_count); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_addr = 17'd5; wr_color = 15'h1234;
    #1;
    n_checks++; if (buf1_we !== 1'b1 || buf1_ce !== 1'b1) begin n_fail++; $display("FAIL write_buf1_we_ce: got %b%b want 11", buf1_we, buf1_ce); end
    n_checks++; if (buf1_address !== 17'd5) begin n_fail++; $display("FAIL write_buf1_address: got %0d want 5", buf1_address); end
    n_checks++; if (buf1_din !== 15'h1234) begin n_fail++; $display("FAIL write_buf1_din: got %h want 1234", buf1_din); end
    n_checks++; if (buf0_we !== 1'b0 || buf0_din !== 15'h0) begin n_fail++; $display("FAIL write_buf0_idle: got we=%b din=%h want 0/0", buf0_we, buf0_din); end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_swap();
    int low_cycles = 0;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (wr_ready === 1'b0) low_cycles++;
      n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL hold_toggle cycle %0d: got %b want 0", i, toggle); end
      if (i == 3) begin
        wr_en = 1'b1; wr_addr = 17'd5; wr_color = 15'h5555;
        #1;
        n_checks++; if (buf1_we !== 1'b0 || buf0_we !== 1'b0) begin n_fail++; $display("FAIL hold_write_ignored: got we1=%b we0=%b want 0/0", buf1_we, buf0_we); end
      end
      if (i == 10) rd_frame_done = 1'b1;
      tick();
      wr_en = 1'b0;
    end
    rd_frame_done = 1'b0;
    if (wr_ready === 1'b0) low_cycles++;
    n_checks++; if (toggle !== 1'b1) begin n_fail++; $display("FAIL swap_toggle: got %b want 1", toggle); end
    n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL swap_front_sel_old: got %b want 0", front_sel); end
    wr_en = 1'b1; wr_addr = 17'd5; wr_color = 15'h5555;
    rd_en = 1'b1; rd_addr = 17'd5;
    #1;
    n_checks++; if (buf1_we !== 1'b0 || buf0_we !== 1'b0) begin n_fail++; $display("FAIL swap_write_ignored: got we1=%b we0=%b want 0/0", buf1_we, buf0_we); end
    tick();
    wr_en = 1'b0;
    if (wr_ready === 1'b0) low_cycles++;
    n_checks++; if (low_cycles !== 11) begin n_fail++; $display("FAIL wr_ready_low_cycles: got %0d want 11", low_cycles); end
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL after_swap_toggle: got %b want 0", toggle); end
    n_checks++; if (front_sel !== 1'b1) begin n_fail++; $display("FAIL after_swap_front_sel: got %b want 1", front_sel); end
    n_checks++; if (rd_valid !== 1'b1 || rd_color !== 15'h0abc) begin n_fail++; $display("FAIL read_during_swap: got v=%b %h want 1 0abc", rd_valid, rd_color); end
    #1;
    n_checks++; if (buf1_ce !== 1'b1 || buf1_we !== 1'b0 || buf1_address !== 17'd5 || buf0_ce !== 1'b0) begin n_fail++; $display("FAIL read_port_route: got ce1=%b we1=%b a1=%0d ce0=%b want 1 0 5 0", buf1_ce, buf1_we, buf1_address, buf0_ce); end
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || rd_color !== 15'h1234) begin n_fail++; $display("FAIL read_new_front: got v=%b %h want 1 1234", rd_valid, rd_color); end
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] rc0;
    rc0 = repeat_count;
    wr_frame_done = 1'b1; rd_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0; rd_frame_done = 1'b0;
    n_checks++; if (toggle !== 1'b1) begin n_fail++; $display("FAIL simul_toggle: got %b want 1", toggle); end
    n_checks++; if (repeat_count !== rc0) begin n_fail++; $display("FAIL simul_repeat_count: got %0d want %0d", repeat_count, rc0); end
    tick();
    n_checks++; if (toggle !== 1'b0 || front_sel !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL simul_after: got t=%b fs=%b rdy=%b want 0 0 1", toggle, front_sel, wr_ready); end
  endtask

  task automatic test_repeat();
    logic [15:0] exp_rc;
`ifdef FRAME_STATS_EN
    exp_rc = 16'd3;
`else
    exp_rc = 16'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      rd_frame_done = 1'b1;
      tick();
      rd_frame_done = 1'b0;
      n_checks++; if (toggle !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL repeat_stay_fill %0d: got t=%b rdy=%b want 0 1", i, toggle, wr_ready); end
      tick();
    end
    n_checks++; if (repeat_count !== exp_rc) begin n_fail++; $display("FAIL repeat_count: got %0d want %0d", repeat_count, exp_rc); end
    n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL repeat_front_sel: got %b want 0", front_sel); end
  endtask

  task automatic test_oob();
    wr_en = 1'b1; wr_addr = 17'd38400; wr_color = 15'h2222;
    #1;
    n_checks++; if (buf0_we !== 1'b0 || buf1_we !== 1'b0 || buf1_ce !== 1'b0) begin n_fail++; $display("FAIL oob_write_dropped: got we0=%b we1=%b ce1=%b want 0 0 0", buf0_we, buf1_we, buf1_ce); end
    wr_addr = 17'd38399;
    #1;
    n_checks++; if (buf1_we !== 1'b1 || buf1_address !== 17'd38399) begin n_fail++; $display("FAIL last_pixel_write: got we1=%b a=%0d want 1 38399", buf1_we, buf1_address); end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 17'd38400;
    #1;
    n_checks++; if (buf0_ce !== 1'b0) begin n_fail++; $display("FAIL oob_read_no_ce: got %b want 0", buf0_ce); end
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || rd_color !== 15'h0) begin n_fail++; $display("FAIL oob_read: got v=%b %h want 1 0000", rd_valid, rd_color); end
    tick();
  endtask

  task automatic test_reset_hold();
    wr_frame_done = 1'b1; rd_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0; rd_frame_done = 1'b0;
    tick();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    n_checks++; if (front_sel !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_hold: got fs=%b rdy=%b want 1 0", front_sel, wr_ready); end
    reset = 1'b1; rd_frame_done = 1'b1;
    wr_en = 1'b1; wr_addr = 17'd7; wr_color = 15'h0777;
    #1;
    n_checks++; if (buf0_we !== 1'b0 || buf1_we !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_write: got we0=%b we1=%b want 0 0", buf0_we, buf1_we); end
    tick();
    reset = 1'b0; rd_frame_done = 1'b0;
    #1;
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL reset_hold_toggle: got %b want 0", toggle); end
    n_checks++; if (front_sel !== 1'b0) begin n_fail++; $display("FAIL reset_hold_front_sel: got %b want 0", front_sel); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hold_wr_ready: got %b want 1", wr_ready); end
    n_checks++; if (repeat_count !== 16'h0) begin n_fail++; $display("FAIL reset_hold_repeat: got %0d want 0", repeat_count); end
    n_checks++; if (buf1_we !== 1'b1 || buf0_we !== 1'b0) begin n_fail++; $display("FAIL reset_hold_write_back1: got we1=%b we0=%b want 1 0", buf1_we, buf0_we); end
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_swap();
    test_simultaneous();
    test_repeat();
    test_oob();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_swap_arbiter.md
FRAME_SWAP_ARBITER -- requirements
Module: frame_swap_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, buffer address width.
REQ-002 SHALL have parameter DATA_W, default 15, BGR555 pixel width.
REQ-003 SHALL have parameter PIX_COUNT, default 38400, valid pixels per frame (240x160).
REQ-004 SHALL have port clock  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports wr_en / wr_addr / wr_color  input  1 / ADDR_W / DATA_W  graphics-side pixel write.
REQ-007 SHALL have port wr_ready  output  1  write accepted this cycle when high.
REQ-008 SHALL have port wr_frame_done  input  1  one-cycle pulse; graphics finished back frame.
REQ-009 SHALL have ports rd_en / rd_addr  input  1 / ADDR_W  VGA-side read request.
REQ-010 SHALL have ports rd_color / rd_valid  output  DATA_W / 1  read data and its qualifier.
REQ-011 SHALL have port rd_frame_done  input  1  one-cycle pulse; VGA finished scanning front frame.
REQ-012 SHALL have ports toggle / front_sel  output  1 / 1  swap pulse; index of buffer being displayed.
REQ-013 SHALL have ports bufN_address / bufN_din / bufN_we / bufN_ce  output  ADDR_W / DATA_W / 1 / 1, and bufN_dout  input  DATA_W, for N = 0, 1 (1-cycle-latency RAM).
REQ-014 SHALL have port repeat_count  output  16  frames re-displayed because no new frame was ready.

Function
REQ-015 SHALL route the back buffer (index ~front_sel) to the writer and the front buffer (index front_sel) to the reader, never both sides to one buffer.
REQ-016 SHALL implement states FILL, HOLD, SWAP.
REQ-017 FILL: wr_ready = 1; wr_frame_done -> HOLD.
REQ-018 HOLD: wr_ready = 0, wr_en ignored; rd_frame_done -> SWAP.
REQ-019 SWAP (exactly one cycle): toggle = 1, wr_ready = 0, front_sel inverts at the end of the cycle; -> FILL.
REQ-020 wr_frame_done and rd_frame_done in the same FILL cycle SHALL go directly to SWAP.
REQ-021 rd_frame_done in FILL without wr_frame_done SHALL stay in FILL and increment repeat_count, saturating at 0xFFFF.
REQ-022 wr_frame_done in HOLD or SWAP SHALL be ignored.
REQ-023 Back-buffer write SHALL occur (we = ce = 1) only when wr_en & wr_ready & wr_addr < PIX_COUNT; out-of-range writes are dropped silently.
REQ-024 rd_valid SHALL assert exactly one cycle after rd_en; rd_color is taken from the buffer that was front when rd_en was sampled (registered select), including rd_en issued during SWAP (old front).
REQ-025 rd_addr >= PIX_COUNT SHALL return rd_color = 0 with rd_valid = 1.
REQ-026 Inactive buffer-port fields SHALL drive zero; bufN_din = wr_color only on the back buffer.

Reset
REQ-027 Reset SHALL set state FILL, front_sel 0, toggle 0, rd_valid 0, rd_color 0, repeat_count 0.
REQ-028 Reset asserted mid-frame or in HOLD/SWAP SHALL abandon the frame with no toggle pulse, and SHALL suppress any buffer write in the reset cycle.
REQ-029 wr_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-030 Macro FRAME_STATS_EN SHALL compile in the repeat_count counter; without it, repeat_count is tied to 0 and no counter flops exist; the port is present in both builds.

Structure
REQ-031 State enum (FILL, HOLD, SWAP) and the PIX_COUNT default SHALL live in shared package gfx_fb_pkg.
REQ-032 Buffer-port steering SHALL be sub-module fb_port_mux (front_sel plus both request sides in, two RAM port bundles out); the FSM, read-select register and counter stay in the top module.

Verification
REQ-033 Reset, write addr 5 = 0x1234 with wr_en -> buf1_we = 1, buf1_address = 5, buf0_we = 0.
REQ-034 wr_frame_done, then rd_frame_done 10 cycles later -> wr_ready low 11 cycles, toggle high for 1 cycle, front_sel = 1 afterwards, rd of addr 5 returns 0x1234 with rd_valid one cycle later.
REQ-035 Simultaneous wr_frame_done + rd_frame_done in FILL -> SWAP next cycle, toggle pulse, repeat_count unchanged.
REQ-036 Three rd_frame_done with no wr_frame_done -> repeat_count = 3, front_sel unchanged; without FRAME_STATS_EN, repeat_count = 0.
REQ-037 wr_addr = 38400 with wr_en -> no we on either buffer; rd_addr = 38400 -> rd_color = 0, rd_valid = 1.
REQ-038 Reset asserted in HOLD -> next cycle state FILL, front_sel = 0, wr_ready = 1, no toggle.
